// File: rtl/h264_feeder_pkg.sv
// Shared types and address-map helpers for the h264 macroblock feeder.
// Contents:
//   state_t        - scheduler FSM states
//   plane_t        - which YUV420 plane an address refers to
//   u_base/v_base  - word base addresses of the U and V planes
package h264_feeder_pkg;

  typedef enum logic [2:0] {IDLE, ARB, LBURST, CBURST, ROWWAIT, DONE} state_t;

  typedef enum logic [1:0] {Y, U, V} plane_t;

  // The U plane follows the luma plane: W*H bytes is W*H/4 words.
  function automatic int unsigned u_base(input int unsigned w, input int unsigned h);
    return (w * h) / 4;
  endfunction

  // The V plane follows U, which holds (W/2)*(H/2) bytes = W*H/16 words.
  function automatic int unsigned v_base(input int unsigned w, input int unsigned h);
    return (w * h) / 4 + (w * h) / 16;
  endfunction

endpackage

// File: rtl/h264_feeder_addrgen.sv
// Pure combinational word-address generator for the macroblock feeder.
// Ports:
//   plane  - Y, U or V
//   mb_x   - luma pixel x of the macroblock's left edge (steps of 16)
//   row    - macroblock row index
//   burst  - burst index inside the macroblock (luma 0..7, chroma 0..3)
//   beat   - beat index inside the burst (0..7)
//   addr   - resulting word address
module h264_feeder_addrgen
  import h264_feeder_pkg::*;
#(
  parameter int IMGWIDTH  = 352,
  parameter int IMGHEIGHT = 288,
  parameter int IWBITS    = 9,
  parameter int AWIDTH    = 16
) (
  input  plane_t              plane,
  input  logic [IWBITS-1:0]   mb_x,
  input  logic [IWBITS-1:0]   row,
  input  logic [2:0]          burst,
  input  logic [2:0]          beat,
  output logic [AWIDTH-1:0]   addr
);

  localparam logic [AWIDTH-1:0] LUMA_STRIDE   = AWIDTH'(IMGWIDTH / 4);
  localparam logic [AWIDTH-1:0] CHROMA_STRIDE = AWIDTH'(IMGWIDTH / 8);
  localparam logic [AWIDTH-1:0] UB            = AWIDTH'(u_base(IMGWIDTH, IMGHEIGHT));
  localparam logic [AWIDTH-1:0] VB            = AWIDTH'(v_base(IMGWIDTH, IMGHEIGHT));

  logic [AWIDTH-1:0] luma_y;
  logic [AWIDTH-1:0] chroma_y;
  logic [AWIDTH-1:0] luma_addr;
  logic [AWIDTH-1:0] chroma_off;

  // Luma burst b covers pixel rows 2b and 2b+1 of the MB, four words per row.
  // Chroma burst b[0] selects the upper or lower four rows, two words per row;
  // the chroma x of the MB is mb_x/2, so its word offset is mb_x/8.
  always_comb begin
    luma_y     = (AWIDTH'(row) << 4) + (AWIDTH'(burst) << 1) + AWIDTH'(beat[2]);
    chroma_y   = (AWIDTH'(row) << 3) + (AWIDTH'(burst[0]) << 2) + AWIDTH'(beat[2:1]);
    luma_addr  = luma_y * LUMA_STRIDE + (AWIDTH'(mb_x) >> 2) + AWIDTH'(beat[1:0]);
    chroma_off = chroma_y * CHROMA_STRIDE + (AWIDTH'(mb_x) >> 3) + AWIDTH'(beat[0]);
    case (plane)
      Y:       addr = luma_addr;
      U:       addr = UB + chroma_off;
      V:       addr = VB + chroma_off;
      default: addr = '0;
    endcase
  end

endmodule

// File: rtl/h264_mb_feeder.sv
// Input scheduler for the h264 skeleton: reads a planar YUV420 frame from
// word memory and streams luma 16x2 bursts to intra4x4 and chroma bursts to
// intra8x8cc, one macroblock row at a time, pacing rows on xbuffer_DONE.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start / busy / frame_done  - frame control handshake
//   mem_rd, mem_addr, mem_data - shared memory read port (1-cycle latency)
//   NEWSLICE, NEWLINE          - frame / macroblock-row start markers
//   xbuffer_DONE               - skeleton has drained the current row
//   intra4x4_*                 - luma consumer (READYI, STROBEI, DATAI)
//   intra8x8cc_*               - chroma consumer (READYI, STROBEI, DATAI)
module h264_mb_feeder
  import h264_feeder_pkg::*;
#(
  parameter int IMGWIDTH  = 352,
  parameter int IMGHEIGHT = 288,
  parameter int IWBITS    = 9,
  parameter int AWIDTH    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              NEWSLICE,
  output logic              NEWLINE,
  input  logic              xbuffer_DONE,
  input  logic              intra4x4_READYI,
  output logic              intra4x4_STROBEI,
  output logic [31:0]       intra4x4_DATAI,
  input  logic              intra8x8cc_READYI,
  output logic              intra8x8cc_STROBEI,
  output logic [31:0]       intra8x8cc_DATAI
);

  localparam logic [IWBITS-1:0] LAST_X   = IWBITS'(IMGWIDTH - 16);
  localparam logic [IWBITS-1:0] LAST_ROW = IWBITS'(IMGHEIGHT / 16 - 1);

  state_t            state;
  logic [IWBITS-1:0] row;
  logic [IWBITS-1:0] luma_x;
  logic [IWBITS-1:0] chroma_x;
  logic [2:0]        luma_burst;
  logic [1:0]        chroma_burst;
  logic [2:0]        beat;
  logic              luma_done;
  logic              chroma_done;
  logic              served_luma;
  logic              luma_pipe;
  logic              chroma_pipe;

  logic              luma_elig;
  logic              chroma_elig;
  logic              grant_luma;
  logic              sel_luma;
  plane_t            ag_plane;
  logic [IWBITS-1:0] ag_x;
  logic [2:0]        ag_burst;
  logic [2:0]        ag_beat;
  logic [AWIDTH-1:0] ag_addr;

  // Round-robin grant: on a tie, serve whichever plane was not served last.
  // The shared address generator sees the plane about to be granted while in
  // ARB, otherwise the plane of the running burst with the next beat index.
  always_comb begin
    luma_elig   = !luma_done && intra4x4_READYI;
    chroma_elig = !chroma_done && intra8x8cc_READYI;
    grant_luma  = luma_elig && (!chroma_elig || !served_luma);
    sel_luma    = (state == ARB) ? grant_luma : (state == LBURST);
    ag_plane    = sel_luma ? Y : (chroma_burst[1] ? V : U);
    ag_x        = sel_luma ? luma_x : chroma_x;
    ag_burst    = sel_luma ? luma_burst : {1'b0, chroma_burst};
    ag_beat     = (state == ARB) ? 3'd0 : beat + 3'd1;
  end

  h264_feeder_addrgen #(
    .IMGWIDTH (IMGWIDTH),
    .IMGHEIGHT(IMGHEIGHT),
    .IWBITS   (IWBITS),
    .AWIDTH   (AWIDTH)
  ) u_addrgen (
    .plane(ag_plane),
    .mb_x (ag_x),
    .row  (row),
    .burst(ag_burst),
    .beat (ag_beat),
    .addr (ag_addr)
  );

  // Scheduler FSM plus the two-stage output pipeline (memory latency, then
  // the DATAI register). Markers are cleared by the luma pipeline before the
  // FSM gets a chance to set them again for a new frame or row.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      row                <= '0;
      luma_x             <= '0;
      chroma_x           <= '0;
      luma_burst         <= '0;
      chroma_burst       <= '0;
      beat               <= '0;
      luma_done          <= 1'b0;
      chroma_done        <= 1'b0;
      served_luma        <= 1'b0;
      luma_pipe          <= 1'b0;
      chroma_pipe        <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      mem_rd             <= 1'b0;
      mem_addr           <= '0;
      NEWSLICE           <= 1'b0;
      NEWLINE            <= 1'b0;
      intra4x4_STROBEI   <= 1'b0;
      intra4x4_DATAI     <= '0;
      intra8x8cc_STROBEI <= 1'b0;
      intra8x8cc_DATAI   <= '0;
    end else begin
      frame_done         <= 1'b0;
      luma_pipe          <= mem_rd && (state == LBURST);
      chroma_pipe        <= mem_rd && (state == CBURST);
      intra4x4_STROBEI   <= luma_pipe;
      intra8x8cc_STROBEI <= chroma_pipe;
      if (luma_pipe) begin
        intra4x4_DATAI <= mem_data;
        NEWSLICE       <= 1'b0;
        NEWLINE        <= 1'b0;
      end
      if (chroma_pipe) intra8x8cc_DATAI <= mem_data;

      case (state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            NEWSLICE     <= 1'b1;
            NEWLINE      <= 1'b1;
            row          <= '0;
            luma_x       <= '0;
            chroma_x     <= '0;
            luma_burst   <= '0;
            chroma_burst <= '0;
            luma_done    <= 1'b0;
            chroma_done  <= 1'b0;
            served_luma  <= 1'b0;
            state        <= ARB;
          end
        end
        ARB: begin
          if (luma_done && chroma_done) begin
            state <= ROWWAIT;
          end else if (luma_elig || chroma_elig) begin
            mem_rd      <= 1'b1;
            mem_addr    <= ag_addr;
            beat        <= '0;
            served_luma <= grant_luma;
            state       <= grant_luma ? LBURST : CBURST;
          end
        end
        LBURST: begin
          if (beat == 3'd7) begin
            mem_rd <= 1'b0;
            state  <= ARB;
            luma_burst <= luma_burst + 3'd1;
            if (luma_burst == 3'd7) begin
              if (luma_x == LAST_X) luma_done <= 1'b1;
              else                  luma_x    <= luma_x + IWBITS'(16);
            end
          end else begin
            beat     <= beat + 3'd1;
            mem_addr <= ag_addr;
          end
        end
        CBURST: begin
          if (beat == 3'd7) begin
            mem_rd <= 1'b0;
            state  <= ARB;
            chroma_burst <= chroma_burst + 2'd1;
            if (chroma_burst == 2'd3) begin
              if (chroma_x == LAST_X) chroma_done <= 1'b1;
              else                    chroma_x    <= chroma_x + IWBITS'(16);
            end
          end else begin
            beat     <= beat + 3'd1;
            mem_addr <= ag_addr;
          end
        end
        ROWWAIT: begin
          if (xbuffer_DONE) begin
            if (row == LAST_ROW) begin
              state <= DONE;
            end else begin
              row          <= row + IWBITS'(1);
              NEWLINE      <= 1'b1;
              luma_x       <= '0;
              chroma_x     <= '0;
              luma_burst   <= '0;
              chroma_burst <= '0;
              luma_done    <= 1'b0;
              chroma_done  <= 1'b0;
              state        <= ARB;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
